// File: rtl/dlx_pkg.sv
// Shared constants and types for the DLX fetch front end.
// Buses are numbered [0:31], so bit 0 is the MSB.
package dlx_pkg;

  localparam logic [0:31] RESET_PC    = 32'h0000_0000;
  localparam logic [0:31] NOP_INSTR   = 32'h0000_0000;
  localparam logic [0:5]  TRAP_OPCODE = 6'h11;

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } fetch_state_t;

  // Update applied to the IF/ID register group at a clock edge.
  typedef enum logic [1:0] {
    IFID_HOLD,
    IFID_SQUASH,
    IFID_LOAD
  } ifid_op_t;

  function automatic logic is_trap(input logic [0:31] instr);
    return instr[0:5] == TRAP_OPCODE;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register group: holds, squashes to a NOP bubble, or loads a fetched word.
module if_id_reg
  import dlx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  ifid_op_t    op,
  input  logic [0:31] next_instr,
  input  logic [0:31] next_pc4,
  output logic [0:31] instr,
  output logic [0:31] pc4,
  output logic        valid
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= NOP_INSTR;
      pc4   <= '0;
      valid <= 1'b0;
    end else begin
      case (op)
        IFID_LOAD: begin
          instr <= next_instr;
          pc4   <= next_pc4;
          valid <= 1'b1;
        end
        // A bubble keeps the old pc4; decode ignores it while valid is low.
        IFID_SQUASH: begin
          instr <= NOP_INSTR;
          valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALT control and the IF/ID register.
// Priority at each edge: stall_ext, redirect, stall_hazard, then the state action.
module fetch_stage
  import dlx_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ext,
  input  logic        stall_hazard,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_target,
  input  logic [0:31] imem_data,
  output logic [0:31] imem_addr,
  output logic [0:31] if_id_instr,
  output logic [0:31] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted
);

  fetch_state_t state, next_state;
  logic [0:31]  pc, next_pc, pc_plus4;
  ifid_op_t     ifid_op;

  // 32-bit add simply drops the carry, so 0xFFFFFFFC wraps to 0.
  assign pc_plus4  = pc + 32'd4;
  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else begin
      pc    <= next_pc;
      state <= next_state;
    end
  end

  // NOTE: every output of this block is given a default first so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    ifid_op    = IFID_HOLD;
    if (stall_ext) begin
      // Whole pipeline frozen, pending redirect included.
    end else if (redirect_valid) begin
      next_pc    = redirect_target;
      ifid_op    = IFID_SQUASH;
      next_state = ST_RUN;
    end else if (stall_hazard) begin
      // Load-use stall: PC and IF/ID hold.
    end else if (state == ST_HALT) begin
      ifid_op = IFID_SQUASH;
    end else begin
      next_pc = pc_plus4;
      ifid_op = IFID_LOAD;
      if (is_trap(imem_data)) next_state = ST_HALT;
    end
  end

  if_id_reg u_if_id (
    .clk        (clk),
    .reset      (reset),
    .op         (ifid_op),
    .next_instr (imem_data),
    .next_pc4   (pc_plus4),
    .instr      (if_id_instr),
    .pc4        (if_id_pc4),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues hand-computed post-edge
// expectations and a monitor compares them just after each rising edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_ext, stall_hazard, redirect_valid;
  logic [0:31] redirect_target, imem_data;
  logic [0:31] imem_addr, if_id_instr, if_id_pc4;
  logic        if_id_valid, halted;
  logic        trap_mode;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string       name;
    logic [0:31] addr;
    logic [0:31] instr;
    logic [0:31] pc4;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_ext       (stall_ext),
    .stall_hazard    (stall_hazard),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_data       (imem_data),
    .imem_addr       (imem_addr),
    .if_id_instr     (if_id_instr),
    .if_id_pc4       (if_id_pc4),
    .if_id_valid     (if_id_valid),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  // Program image: two real words at 0x0/0x4, optional trap at 0x8,
  // otherwise an address-tagged filler word.
  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_data = 32'h2001_0005;
      32'h0000_0004: imem_data = 32'h2002_0007;
      32'h0000_0008: imem_data = trap_mode ? 32'h4400_0300 : 32'hA000_0008;
      default:       imem_data = 32'hA000_0000 + imem_addr;
    endcase
  end

  task automatic check(input string name, input logic [0:31] act, input logic [0:31] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compare one queued expectation after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".addr"},   imem_addr,   e.addr);
        check({e.name, ".instr"},  if_id_instr, e.instr);
        check({e.name, ".pc4"},    if_id_pc4,   e.pc4);
        check({e.name, ".valid"},  {31'd0, if_id_valid}, {31'd0, e.valid});
        check({e.name, ".halted"}, {31'd0, halted},      {31'd0, e.halted});
      end
    end
  end

  task automatic issue(input logic se, input logic sh, input logic rv, input logic [0:31] tgt,
                       input logic [0:31] ea, input logic [0:31] ei, input logic [0:31] ep,
                       input logic ev, input logic eh, input string nm);
    exp_t e;
    stall_ext       = se;
    stall_hazard    = sh;
    redirect_valid  = rv;
    redirect_target = tgt;
    e.name = nm; e.addr = ea; e.instr = ei; e.pc4 = ep; e.valid = ev; e.halted = eh;
    sb.push_back(e);
  endtask

  task automatic step(input logic se, input logic sh, input logic rv, input logic [0:31] tgt,
                      input logic [0:31] ea, input logic [0:31] ei, input logic [0:31] ep,
                      input logic ev, input logic eh, input string nm);
    @(negedge clk);
    issue(se, sh, rv, tgt, ea, ei, ep, ev, eh, nm);
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  task automatic check_reset_values(input string nm);
    check({nm, ".addr"},   imem_addr,   32'h0);
    check({nm, ".instr"},  if_id_instr, 32'h0);
    check({nm, ".pc4"},    if_id_pc4,   32'h0);
    check({nm, ".valid"},  {31'd0, if_id_valid}, 32'd0);
    check({nm, ".halted"}, {31'd0, halted},      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    trap_mode = 1'b0;
    stall_ext = 0; stall_hazard = 0; redirect_valid = 0; redirect_target = '0;
    #1;
    check_reset_values("reset");

    // Straight-line fetch from RESET_PC.
    @(negedge clk);
    reset = 1'b0;
    issue(0, 0, 0, 0, 32'h4,  32'h2001_0005, 32'h4,  1, 0, "fetch0");
    step (0, 0, 0, 0, 32'h8,  32'h2002_0007, 32'h8,  1, 0, "fetch4");
    step (0, 0, 0, 0, 32'hC,  32'hA000_0008, 32'hC,  1, 0, "fetch8");
    step (0, 0, 0, 0, 32'h10, 32'hA000_000C, 32'h10, 1, 0, "fetchC");

    // 50-cycle external freeze at PC=0x10; redirect and hazard must be ignored.
    for (int i = 0; i < 50; i++)
      step(1, (i % 7) == 0, i == 20, 32'h80, 32'h10, 32'hA000_000C, 32'h10, 1, 0, "stall_ext");
    step (0, 0, 0, 0, 32'h14, 32'hA000_0010, 32'h14, 1, 0, "resume10");
    step (0, 0, 0, 0, 32'h18, 32'hA000_0014, 32'h18, 1, 0, "resume14");

    // Hazard alone holds; redirect beats a simultaneous hazard.
    step (0, 1, 0, 0,      32'h18, 32'hA000_0014, 32'h18, 1, 0, "hazard");
    step (0, 1, 1, 32'h40, 32'h40, 32'h0000_0000, 32'h18, 0, 0, "redir_hazard");
    step (0, 0, 0, 0,      32'h44, 32'hA000_0040, 32'h44, 1, 0, "fetch40");

    // Trap at 0x8 enters HALT; a redirect returns to RUN.
    trap_mode = 1'b1;
    step (0, 0, 1, 32'h0, 32'h0, 32'h0,          32'h44, 0, 0, "redir0");
    step (0, 0, 0, 0,     32'h4, 32'h2001_0005,  32'h4,  1, 0, "t_fetch0");
    step (0, 0, 0, 0,     32'h8, 32'h2002_0007,  32'h8,  1, 0, "t_fetch4");
    step (0, 0, 0, 0,     32'hC, 32'h4400_0300,  32'hC,  1, 1, "trap");
    step (0, 0, 0, 0,     32'hC, 32'h0,          32'hC,  0, 1, "halt1");
    step (0, 0, 0, 0,     32'hC, 32'h0,          32'hC,  0, 1, "halt2");
    step (0, 1, 0, 0,     32'hC, 32'h0,          32'hC,  0, 1, "halt_hazard");
    step (0, 0, 1, 32'h0, 32'h0, 32'h0,          32'hC,  0, 0, "unhalt");
    step (0, 0, 0, 0,     32'h4, 32'h2001_0005,  32'h4,  1, 0, "unhalt_fetch");

    // PC+4 wraps from 0xFFFFFFFC to 0.
    step (0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h4, 0, 0, "redir_top");
    step (0, 0, 0, 0,             32'h0,         32'h9FFF_FFFC, 32'h0, 1, 0, "wrap");
    step (0, 0, 0, 0,             32'h4,         32'h2001_0005, 32'h4, 1, 0, "post_wrap");
    step (0, 0, 0, 0,             32'h8,         32'h2002_0007, 32'h8, 1, 0, "w_fetch4");
    step (0, 0, 0, 0,             32'hC,         32'h4400_0300, 32'hC, 1, 1, "trap2");
    drain();

    // Asynchronous reset pulse while halted, between clock edges.
    @(negedge clk);
    #1 reset = 1'b1;
    #1 check_reset_values("async_reset");
    #1 reset = 1'b0;
    issue(0, 0, 0, 0, 32'h4, 32'h2001_0005, 32'h4, 1, 0, "after_reset");
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
